sprite_mem_arbiter: RTL
=======================

Name: sprite_mem_arbiter

Overview:
- Shares the single sprite-table BRAM port B between two requesters:
  - R0 is the display-side sprite loader, which only reads.
  - R1 is the game-logic engine, which reads and writes positions and directions.
- Per-access valid/grant handshake, optional multi-access lock with timeout, and per-requester read-return tagging.
- Sits between the requesters and the BRAM port B pins (addr_b, data_b, we_b, q_b).

Parameters:
ADDR_W, 10, BRAM word-address width
DATA_W, 16, BRAM word width
LOCK_MAX, 64, max consecutive cycles a lock may be held before forced release (>=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req0  in  1  R0 read request; held with addr0 until gnt0
lock0  in  1  R0 requests exclusive ownership across accesses
addr0  in  ADDR_W  R0 read address
gnt0  out  1  combinational; R0 access accepted at this clock edge
rvalid0  out  1  rdata0 valid this cycle
rdata0  out  DATA_W  read data for R0
req1  in  1  R1 request
lock1  in  1  R1 exclusive ownership request
addr1  in  ADDR_W  R1 address
wdata1  in  DATA_W  R1 write data
we1  in  1  R1 access is a write (1) or read (0)
gnt1  out  1  combinational; R1 access accepted at this edge
rvalid1  out  1  rdata1 valid this cycle
rdata1  out  DATA_W  read data for R1
addr_b  out  ADDR_W  BRAM port B address (registered)
data_b  out  DATA_W  BRAM port B write data (registered)
we_b  out  1  BRAM port B write enable (registered)
q_b  in  DATA_W  BRAM port B read data; valid one cycle after addr_b presented
lock_err  out  1  one-cycle pulse when a lock is force-released

Behaviour:
- Reset values:
  - addr_b=0, data_b=0, we_b=0.
  - gnt0/gnt1 low.
  - rvalid0/rvalid1=0, lock_err=0.
  - state=ARB_IDLE, last-grant pointer=R1 (so R0 wins first tie), lock counter=0.
  - Read-return pipeline cleared; in-flight reads at reset are discarded and never return.
- Grant: at most one of gnt0/gnt1 per cycle; gnt only when the corresponding req=1.
  - At the edge ending a grant cycle, addr_b/data_b/we_b are registered from the winner. R0 always registers we_b=0.
  - In non-grant cycles we_b<=0; addr_b and data_b hold.
- Read latency, with grant in cycle T:
  - addr_b is presented in T+1.
  - q_b is valid in T+2.
  - rvalidN=1 in T+2 for the granting requester, with rdataN=q_b (combinational pass-through).
  - Writes produce no rvalid.
  - Back-to-back grants allowed every cycle, giving one rvalid per cycle, in order, correctly tagged.
- rdata0/rdata1 equal q_b at all times; meaningful only when the matching rvalid=1.
- States:
  - ARB_IDLE:
    - Only one req set: grant it.
    - Both set: grant the requester not in the last-grant pointer (round-robin).
    - Update the pointer on every grant.
    - If the winner's lock=1 in the grant cycle, go to ARB_LOCKn and set the counter to 1.
  - ARB_LOCKn:
    - Only Rn may be granted; the other req is ignored, even if the owner is idle.
    - Counter increments each cycle.
    - lockn=0 sampled at an edge: go to ARB_IDLE. Grants from that next cycle use ARB_IDLE rules.
    - Counter reaching LOCK_MAX with lockn still 1: go to ARB_IDLE, pulse lock_err for one cycle, and set the pointer to n so the other requester wins the next tie.
    - The owner cannot re-lock in the same cycle it was force-released; lock is re-evaluated only on its next grant.
- A lock is taken only via a grant. lock asserted without req has no effect in ARB_IDLE.
- Simultaneous lock0 and lock1 in ARB_IDLE with both req: the round-robin winner takes the lock, and the loser waits.
- Reset mid-lock: returns to ARB_IDLE with all outputs at reset values the next cycle.
- Counter width: clog2(LOCK_MAX)+1 bits; no wrap.

Optional Feature:
- Macro SPRITE_ARB_FIXED_PRI_EN.
- Defined: the ARB_IDLE tie-break is fixed priority to R0, so R0 always wins when both req; the pointer is still tracked but unused. The lock_err force-release rule is unchanged.
- Undefined: round-robin as above.

Test Plan:
- Reset, then req0=1, addr0=5, BRAM[5]=0x1234 -> gnt0 high in cycle 0; addr_b=5 in cycle 1; rvalid0=1 with rdata0=0x1234 in cycle 2; rvalid1 stays 0.
- req0 and req1 both held high (reads of addr 1 and 2) for 4 cycles -> grants alternate R0,R1,R0,R1. With SPRITE_ARB_FIXED_PRI_EN defined -> R0 granted all 4 cycles.
- R1 write sequence:
  - Step 1: req1=1, we1=1, addr1=3, wdata1=0x0050 -> gnt1 high, then we_b=1, addr_b=3, data_b=0x0050 for exactly 1 cycle.
  - Step 2: R1 read of addr 3 -> rvalid1 with rdata1=0x0050.
- Lock path: R1 granted with lock1=1, then req0=1 continuously -> gnt0=0 while lock1 held for 10 cycles; lock1 drops -> gnt0 within 2 cycles.
- Lock timeout: LOCK_MAX=8, R1 holds lock1 and req1 -> lock_err pulses exactly once at counter=8; the next tie goes to R0; R1 never granted 9 consecutive locked cycles.
- Reset asserted 1 cycle after two pipelined read grants -> no rvalid0/rvalid1 afterwards, we_b=0, addr_b=0.

Source files
------------

// File: rtl/sprite_mem_arbiter.sv
// -----------------------------------------------------------------------------
// sprite_mem_arbiter
//
// Shares the single sprite-table BRAM port B between two requesters:
//   R0 - display-side sprite loader (read only)
//   R1 - game-logic engine (read and write)
//
// Each access uses a valid/grant handshake. A requester may take exclusive
// ownership of the port across several accesses (lock), bounded by LOCK_MAX
// cycles. When ownership is forcibly withdrawn, lock_err pulses for one cycle.
// Read returns are tagged so that each read lands on the rvalid of the
// requester that issued it, two cycles after its grant.
//
// Optional build macro:
//   SPRITE_ARB_FIXED_PRI_EN - when defined, R0 always wins a tie in the idle
//                             state instead of round-robin. The lock timeout
//                             behaviour is unchanged.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   req0/lock0/addr0      R0 read request, lock request, address
//   gnt0                  combinational grant for R0
//   rvalid0/rdata0        R0 read return (rdata0 always mirrors q_b)
//   req1/lock1/addr1      R1 request, lock request, address
//   wdata1/we1            R1 write data and write/read select
//   gnt1                  combinational grant for R1
//   rvalid1/rdata1        R1 read return (rdata1 always mirrors q_b)
//   addr_b/data_b/we_b    registered BRAM port B controls
//   q_b                   BRAM port B read data, one cycle after addr_b
//   lock_err              one-cycle pulse on forced lock release
// -----------------------------------------------------------------------------
module sprite_mem_arbiter #(
   parameter int unsigned ADDR_W   = 10,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned LOCK_MAX = 64
) (
   input  logic              clk,
   input  logic              reset,
   // R0: display-side loader
   input  logic              req0,
   input  logic              lock0,
   input  logic [ADDR_W-1:0] addr0,
   output logic              gnt0,
   output logic              rvalid0,
   output logic [DATA_W-1:0] rdata0,
   // R1: game-logic engine
   input  logic              req1,
   input  logic              lock1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   input  logic              we1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   // BRAM port B
   output logic [ADDR_W-1:0] addr_b,
   output logic [DATA_W-1:0] data_b,
   output logic              we_b,
   input  logic [DATA_W-1:0] q_b,
   // Status
   output logic              lock_err
);

   // Counter holds values 0..LOCK_MAX without wrapping.
   localparam int unsigned CNT_W = $clog2(LOCK_MAX) + 1;
   localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CntMax  = CNT_W'(LOCK_MAX);
   // The grant cycle counts as the first held cycle, so the release decision
   // is taken in the cycle whose count is one short of the limit.
   localparam logic [CNT_W-1:0] CntLast = CNT_W'(LOCK_MAX - 1);

   typedef enum logic [1:0] {
      ArbIdle  = 2'd0,
      ArbLock0 = 2'd1,
      ArbLock1 = 2'd2
   } state_e;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              last_q, last_d;      // 0: R0 granted last, 1: R1 granted last
   logic              lock_err_q, lock_err_d;

   logic [ADDR_W-1:0] addr_b_q, addr_b_d;
   logic [DATA_W-1:0] data_b_q, data_b_d;
   logic              we_b_q, we_b_d;

   // Read-return pipeline: stage 1 while addr_b is on the pins, stage 2 while
   // q_b carries the data. Tag 0 = R0, tag 1 = R1.
   logic              s1_v_q, s1_v_d;
   logic              s1_tag_q, s1_tag_d;
   logic              s2_v_q, s2_v_d;
   logic              s2_tag_q, s2_tag_d;

   logic              win0, win1;
   logic              own_lock;

   // ---------------------------------------------------------------------------
   // Arbitration (combinational grants)
   // ---------------------------------------------------------------------------
   always_comb begin
      win0 = 1'b0;
      win1 = 1'b0;
      if (!reset) begin
         case (state_q)
            ArbIdle: begin
               if (req0 && req1) begin
`ifdef SPRITE_ARB_FIXED_PRI_EN
                  win0 = 1'b1;
`else
                  // Round-robin: the requester that did not win last time.
                  win0 = last_q;
                  win1 = ~last_q;
`endif
               end else begin
                  win0 = req0;
                  win1 = req1;
               end
            end
            // While locked only the owner may be served, even if it is idle.
            ArbLock0: win0 = req0;
            ArbLock1: win1 = req1;
            default: begin
               win0 = 1'b0;
               win1 = 1'b0;
            end
         endcase
      end
   end

   assign gnt0 = win0;
   assign gnt1 = win1;

   assign own_lock = (state_q == ArbLock0) ? lock0 : lock1;

   // ---------------------------------------------------------------------------
   // Lock FSM next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      lock_err_d = 1'b0;

      if (win0) begin
         last_d = 1'b0;
      end else if (win1) begin
         last_d = 1'b1;
      end

      case (state_q)
         ArbIdle: begin
            cnt_d = '0;
            // A lock is only ever taken through a grant.
            if (win0 && lock0) begin
               state_d = ArbLock0;
               cnt_d   = CntOne;
            end else if (win1 && lock1) begin
               state_d = ArbLock1;
               cnt_d   = CntOne;
            end
         end
         ArbLock0, ArbLock1: begin
            if (!own_lock) begin
               state_d = ArbIdle;
               cnt_d   = '0;
            end else if (cnt_q == CntLast) begin
               // Forced release: the owner is recorded as last winner so the
               // other requester takes the next tie.
               state_d    = ArbIdle;
               cnt_d      = CntMax;
               lock_err_d = 1'b1;
               last_d     = (state_q == ArbLock1);
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         default: begin
            state_d = ArbIdle;
            cnt_d   = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // BRAM port B controls and read tagging
   // ---------------------------------------------------------------------------
   always_comb begin
      addr_b_d = addr_b_q;
      data_b_d = data_b_q;
      we_b_d   = 1'b0;
      if (win0) begin
         addr_b_d = addr0;
      end else if (win1) begin
         addr_b_d = addr1;
         data_b_d = wdata1;
         we_b_d   = we1;
      end

      s1_v_d   = win0 | (win1 & ~we1);
      s1_tag_d = win1;
      s2_v_d   = s1_v_q;
      s2_tag_d = s1_tag_q;
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ArbIdle;
         cnt_q      <= '0;
         last_q     <= 1'b1;
         lock_err_q <= 1'b0;
         addr_b_q   <= '0;
         data_b_q   <= '0;
         we_b_q     <= 1'b0;
         s1_v_q     <= 1'b0;
         s1_tag_q   <= 1'b0;
         s2_v_q     <= 1'b0;
         s2_tag_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         lock_err_q <= lock_err_d;
         addr_b_q   <= addr_b_d;
         data_b_q   <= data_b_d;
         we_b_q     <= we_b_d;
         s1_v_q     <= s1_v_d;
         s1_tag_q   <= s1_tag_d;
         s2_v_q     <= s2_v_d;
         s2_tag_q   <= s2_tag_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign addr_b   = addr_b_q;
   assign data_b   = data_b_q;
   assign we_b     = we_b_q;
   assign lock_err = lock_err_q;

   assign rvalid0  = s2_v_q & ~s2_tag_q;
   assign rvalid1  = s2_v_q & s2_tag_q;
   assign rdata0   = q_b;
   assign rdata1   = q_b;

   // Structural sanity: grants are exclusive and never unrequested.
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(gnt0 && gnt1));
         assert (!gnt0 || req0);
         assert (!gnt1 || req1);
         assert (cnt_q <= CntMax);
      end
   end

endmodule
